ysyx_22041461_mem_arbiter: RTL and testbench

Arbitrates the CPU's two memory requesters, instruction fetch (read-only) and the MEM stage (read/write), onto a single AXI4-Lite master port toward the memory/peripheral bus. It sits directly downstream of the pipelined CPU core.
- Each side sees a simple valid/ready request channel and a one-cycle response pulse.
- One transaction is outstanding at a time.
- The MEM stage has fixed priority over IF.

---
 rtl/ysyx_22041461_mem_arbiter.sv | 232 +++++++++++++++++++++++
 tb/tb_ysyx_22041461_mem_arbiter.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22041461_mem_arbiter.sv
// ---------------------------------------------------------------------------
// ysyx_22041461_mem_arbiter
//
// Puts the CPU's two memory requesters onto one AXI4-Lite master port. The
// requesters are instruction fetch (IF, read-only) and the MEM stage
// (load/store). Only one transaction is outstanding at a time, and MEM has
// fixed priority over IF.
//
// Ports
//   clk, rst              single clock; synchronous active-low reset
//   if_req_*              IF request channel (valid/ready, 64-bit address)
//   if_rsp_*              IF one-cycle response pulse, raw 64-bit beat, error
//   mem_req_*             MEM request channel (wen, address, wdata, wstrb)
//   mem_rsp_*             MEM one-cycle response pulse (load data or 0), error
//   aw*/w*/b*             AXI4-Lite write address / data / response
//   ar*/r*                AXI4-Lite read address / data
// ---------------------------------------------------------------------------
module ysyx_22041461_mem_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req_valid,
    output logic        if_req_ready,
    input  logic [63:0] if_req_addr,
    output logic        if_rsp_valid,
    output logic [63:0] if_rsp_data,
    output logic        if_rsp_err,
    input  logic        mem_req_valid,
    output logic        mem_req_ready,
    input  logic        mem_req_wen,
    input  logic [63:0] mem_req_addr,
    input  logic [63:0] mem_req_wdata,
    input  logic [7:0]  mem_req_wstrb,
    output logic        mem_rsp_valid,
    output logic [63:0] mem_rsp_rdata,
    output logic        mem_rsp_err,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] awaddr,
    output logic [2:0]  awprot,
    output logic        wvalid,
    input  logic        wready,
    output logic [63:0] wdata,
    output logic [7:0]  wstrb,
    input  logic        bvalid,
    output logic        bready,
    input  logic [1:0]  bresp,
    output logic        arvalid,
    input  logic        arready,
    output logic [31:0] araddr,
    output logic [2:0]  arprot,
    input  logic        rvalid,
    output logic        rready,
    input  logic [63:0] rdata,
    input  logic [1:0]  rresp
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        MRD_AR  = 3'd1,
        MRD_R   = 3'd2,
        MWR_AWW = 3'd3,
        MWR_B   = 3'd4,
        IRD_AR  = 3'd5,
        IRD_R   = 3'd6
    } state_t;

    state_t      state_q;
    logic [31:0] addr_q;
    logic [63:0] wdata_q;
    logic [7:0]  wstrb_q;
    logic        owner_mem_q;
    logic        aw_done_q;
    logic        w_done_q;
    logic        arvalid_q;
    logic [2:0]  arprot_q;
    logic        awvalid_q;
    logic        wvalid_q;
    logic        rready_q;
    logic        bready_q;
    logic [63:0] if_data_q;
    logic        if_err_q;
    logic [63:0] mem_data_q;
    logic        mem_err_q;

    logic        aw_fin;
    logic        w_fin;
    logic        mem_rd_fire;
    logic        mem_wr_fire;

    // Only the low 32 address bits reach the bus.
    logic        unused_addr_hi;
    assign unused_addr_hi = ^{if_req_addr[63:32], mem_req_addr[63:32], owner_mem_q};

    // Grant is combinational from the current-cycle valids; MEM wins ties.
    assign mem_req_ready = rst && (state_q == IDLE) && mem_req_valid;
    assign if_req_ready  = rst && (state_q == IDLE) && if_req_valid && !mem_req_valid;

    // A write channel is finished once its handshake has happened, either
    // in an earlier cycle (done flag) or in this one.
    assign aw_fin = aw_done_q || (awvalid_q && awready);
    assign w_fin  = w_done_q  || (wvalid_q  && wready);

    // Response pulses follow the bus response in the same cycle; the owner is
    // implied by the state, so the other side never sees a pulse.
    assign if_rsp_valid  = rst && (state_q == IRD_R) && rvalid;
    assign mem_rd_fire   = rst && (state_q == MRD_R) && rvalid;
    assign mem_wr_fire   = rst && (state_q == MWR_B) && bvalid;
    assign mem_rsp_valid = mem_rd_fire || mem_wr_fire;

    // Data outputs show the live beat during a pulse and hold it afterwards.
    assign if_rsp_data   = if_rsp_valid ? rdata : if_data_q;
    assign if_rsp_err    = if_rsp_valid ? (rresp != 2'b00) : if_err_q;
    assign mem_rsp_rdata = mem_rd_fire ? rdata : (mem_wr_fire ? 64'd0 : mem_data_q);
    assign mem_rsp_err   = mem_rd_fire ? (rresp != 2'b00) :
                           (mem_wr_fire ? (bresp != 2'b00) : mem_err_q);

    assign arvalid = arvalid_q;
    assign araddr  = addr_q;
    assign arprot  = arprot_q;
    assign rready  = rready_q;
    assign awvalid = awvalid_q;
    assign awaddr  = addr_q;
    assign awprot  = 3'b000;
    assign wvalid  = wvalid_q;
    assign wdata   = wdata_q;
    assign wstrb   = wstrb_q;
    assign bready  = bready_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            addr_q      <= 32'd0;
            wdata_q     <= 64'd0;
            wstrb_q     <= 8'd0;
            owner_mem_q <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            arprot_q    <= 3'b000;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            rready_q    <= 1'b0;
            bready_q    <= 1'b0;
            if_data_q   <= 64'd0;
            if_err_q    <= 1'b0;
            mem_data_q  <= 64'd0;
            mem_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (mem_req_valid) begin
                        addr_q      <= mem_req_addr[31:0];
                        wdata_q     <= mem_req_wdata;
                        wstrb_q     <= mem_req_wstrb;
                        owner_mem_q <= 1'b1;
                        if (mem_req_wen) begin
                            state_q   <= MWR_AWW;
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            aw_done_q <= 1'b0;
                            w_done_q  <= 1'b0;
                        end else begin
                            state_q   <= MRD_AR;
                            arvalid_q <= 1'b1;
                            arprot_q  <= 3'b000;
                        end
                    end else if (if_req_valid) begin
                        addr_q      <= if_req_addr[31:0];
                        owner_mem_q <= 1'b0;
                        state_q     <= IRD_AR;
                        arvalid_q   <= 1'b1;
                        // Instruction-access attribute on fetches.
                        arprot_q    <= 3'b100;
                    end
                end
                MRD_AR, IRD_AR: begin
                    if (arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= (state_q == MRD_AR) ? MRD_R : IRD_R;
                    end
                end
                MRD_R: begin
                    if (rvalid) begin
                        rready_q   <= 1'b0;
                        mem_data_q <= rdata;
                        mem_err_q  <= (rresp != 2'b00);
                        state_q    <= IDLE;
                    end
                end
                IRD_R: begin
                    if (rvalid) begin
                        rready_q  <= 1'b0;
                        if_data_q <= rdata;
                        if_err_q  <= (rresp != 2'b00);
                        state_q   <= IDLE;
                    end
                end
                MWR_AWW: begin
                    // AW and W complete independently; each valid drops
                    // right after its own handshake.
                    if (awvalid_q && awready) begin
                        awvalid_q <= 1'b0;
                        aw_done_q <= 1'b1;
                    end
                    if (wvalid_q && wready) begin
                        wvalid_q <= 1'b0;
                        w_done_q <= 1'b1;
                    end
                    if (aw_fin && w_fin) begin
                        state_q  <= MWR_B;
                        bready_q <= 1'b1;
                    end
                end
                MWR_B: begin
                    if (bvalid) begin
                        bready_q   <= 1'b0;
                        aw_done_q  <= 1'b0;
                        w_done_q   <= 1'b0;
                        mem_data_q <= 64'd0;
                        mem_err_q  <= (bresp != 2'b00);
                        state_q    <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22041461_mem_arbiter.sv
module tb_ysyx_22041461_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req_valid, if_req_ready;
    logic [63:0] if_req_addr;
    logic        if_rsp_valid;
    logic [63:0] if_rsp_data;
    logic        if_rsp_err;
    logic        mem_req_valid, mem_req_ready, mem_req_wen;
    logic [63:0] mem_req_addr, mem_req_wdata;
    logic [7:0]  mem_req_wstrb;
    logic        mem_rsp_valid;
    logic [63:0] mem_rsp_rdata;
    logic        mem_rsp_err;
    logic        awvalid, awready;
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        wvalid, wready;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        bvalid, bready;
    logic [1:0]  bresp;
    logic        arvalid, arready;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        rvalid, rready;
    logic [63:0] rdata;
    logic [1:0]  rresp;

    ysyx_22041461_mem_arbiter dut (
        .clk(clk), .rst(rst),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
        .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data), .if_rsp_err(if_rsp_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_wen(mem_req_wen),
        .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata), .mem_rsp_err(mem_rsp_err),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic        wen;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  wstrb;
    } mreq_t;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    // requester side
    logic        rand_mode = 1'b0;
    logic        if_pend = 1'b0;
    logic [63:0] if_addr_v = 64'd0;
    logic        mem_pend = 1'b0;
    mreq_t       mem_v = '0;
    logic [63:0] if_q[$];
    mreq_t       mem_q[$];

    // slave side
    int          ar_wait = 0, aw_wait = 0, w_wait = 0, rlat = 1, blat = 1;
    int          ar_cnt = 0, aw_cnt = 0, w_cnt = 0;
    logic        r_pend = 1'b0, b_pend = 1'b0, aw_seen = 1'b0, w_seen = 1'b0;
    int          r_cnt = 0, b_cnt = 0;
    logic [63:0] r_data = 64'd0;
    logic [1:0]  r_resp = 2'd0, b_resp = 2'd0;
    logic [1:0]  d_rresp = 2'd0, d_bresp = 2'd0;
    logic [63:0] rq_data[$];

    // transaction-level reference model
    logic        m_busy = 1'b0, m_mem = 1'b0, m_wr = 1'b0, m_a = 1'b0, m_w = 1'b0;
    logic [31:0] m_addr = 32'd0;
    logic [63:0] m_wdata = 64'd0;
    logic [7:0]  m_wstrb = 8'd0;
    logic [63:0] m_last_if = 64'd0, m_last_mem = 64'd0;

    // observation logs for literal checks
    logic [63:0] if_log[$], mem_log[$];
    logic        if_err_log[$], mem_err_log[$];
    logic [31:0] ar_addr_log[$];
    logic [2:0]  ar_prot_log[$];
    int          if_grant_cyc = 0, mem_grant_cyc = 0, if_rsp_cyc = 0, mem_rsp_cyc = 0;
    int          aw_hs_cyc = 0, w_hs_cyc = 0;
    logic [63:0] w_seen_data = 64'd0;
    logic [7:0]  w_seen_strb = 8'd0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int lat_pick(input int fixed);
        return rand_mode ? 1 + int'($urandom_range(2)) : fixed;
    endfunction

    // Drive requesters and slave just after the rising edge.
    task automatic drive_all();
        if (!if_pend) begin
            if (if_q.size() > 0) begin
                if_pend = 1'b1;
                if_addr_v = if_q.pop_front();
            end else if (rand_mode && $urandom_range(3) == 0) begin
                if_pend = 1'b1;
                if_addr_v = {$urandom, $urandom};
            end
        end
        if (!mem_pend) begin
            if (mem_q.size() > 0) begin
                mem_pend = 1'b1;
                mem_v = mem_q.pop_front();
            end else if (rand_mode && $urandom_range(4) == 0) begin
                mem_pend = 1'b1;
                mem_v.wen = 1'($urandom_range(1));
                mem_v.addr = {$urandom, $urandom};
                mem_v.wdata = {$urandom, $urandom};
                mem_v.wstrb = 8'($urandom_range(255));
            end
        end
        if_req_valid  = if_pend;
        if_req_addr   = if_pend ? if_addr_v : {$urandom, $urandom};
        mem_req_valid = mem_pend;
        mem_req_wen   = mem_pend ? mem_v.wen : 1'($urandom_range(1));
        mem_req_addr  = mem_pend ? mem_v.addr : {$urandom, $urandom};
        mem_req_wdata = mem_pend ? mem_v.wdata : {$urandom, $urandom};
        mem_req_wstrb = mem_pend ? mem_v.wstrb : 8'($urandom_range(255));

        arready = rst && arvalid && (rand_mode ? ($urandom_range(2) != 0) : (ar_cnt >= ar_wait));
        awready = rst && awvalid && (rand_mode ? ($urandom_range(2) != 0) : (aw_cnt >= aw_wait));
        wready  = rst && wvalid  && (rand_mode ? ($urandom_range(2) != 0) : (w_cnt >= w_wait));
        rvalid  = rst && r_pend && (r_cnt == 0);
        rdata   = rvalid ? r_data : {$urandom, $urandom};
        rresp   = rvalid ? r_resp : 2'($urandom_range(3));
        bvalid  = rst && b_pend && (b_cnt == 0);
        bresp   = bvalid ? b_resp : 2'($urandom_range(3));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        drive_all();
    endtask

    task automatic wait_if(input int n, input int maxc);
        int c = 0;
        while (if_log.size() < n && c < maxc) begin
            tick();
            c++;
        end
        chk("if_rsp_wait", 64'(if_log.size() >= n), 64'd1);
    endtask

    task automatic wait_mem(input int n, input int maxc);
        int c = 0;
        while (mem_log.size() < n && c < maxc) begin
            tick();
            c++;
        end
        chk("mem_rsp_wait", 64'(mem_log.size() >= n), 64'd1);
    endtask

    task automatic clear_logs();
        if_log.delete(); if_err_log.delete();
        mem_log.delete(); mem_err_log.delete();
        ar_addr_log.delete(); ar_prot_log.delete();
    endtask

    // Single compare process: checks DUT against the model, then advances
    // model, requesters and slave to what the next rising edge will do.
    always @(negedge clk) begin
        logic e_mr, e_ir, e_arv, e_rr, e_awv, e_wv, e_br, e_ifp, e_memp;
        logic [63:0] e_memd;
        cyc++;
        e_mr   = !m_busy && rst && mem_req_valid;
        e_ir   = !m_busy && rst && if_req_valid && !mem_req_valid;
        e_arv  = m_busy && !m_wr && !m_a;
        e_rr   = m_busy && !m_wr && m_a;
        e_awv  = m_busy && m_wr && !m_a;
        e_wv   = m_busy && m_wr && !m_w;
        e_br   = m_busy && m_wr && m_a && m_w;
        e_ifp  = e_rr && !m_mem && rvalid;
        e_memp = m_mem && ((e_rr && rvalid) || (e_br && bvalid));
        e_memd = e_memp ? (m_wr ? 64'd0 : rdata) : m_last_mem;

        chk("mem_req_ready", 64'(mem_req_ready), 64'(e_mr));
        chk("if_req_ready", 64'(if_req_ready), 64'(e_ir));
        chk("arvalid", 64'(arvalid), 64'(e_arv));
        chk("rready", 64'(rready), 64'(e_rr));
        chk("awvalid", 64'(awvalid), 64'(e_awv));
        chk("wvalid", 64'(wvalid), 64'(e_wv));
        chk("bready", 64'(bready), 64'(e_br));
        chk("if_rsp_valid", 64'(if_rsp_valid), 64'(e_ifp));
        chk("mem_rsp_valid", 64'(mem_rsp_valid), 64'(e_memp));
        chk("awprot", 64'(awprot), 64'd0);
        if (e_arv) begin
            chk("araddr", 64'(araddr), 64'(m_addr));
            chk("arprot", 64'(arprot), m_mem ? 64'd0 : 64'd4);
        end
        if (e_awv) chk("awaddr", 64'(awaddr), 64'(m_addr));
        if (e_wv) begin
            chk("wdata", wdata, m_wdata);
            chk("wstrb", 64'(wstrb), 64'(m_wstrb));
        end
        chk("if_rsp_data", if_rsp_data, e_ifp ? rdata : m_last_if);
        chk("mem_rsp_rdata", mem_rsp_rdata, e_memd);
        if (e_ifp) chk("if_rsp_err", 64'(if_rsp_err), 64'(rresp != 2'b00));
        if (e_memp)
            chk("mem_rsp_err", 64'(mem_rsp_err),
                64'(m_wr ? (bresp != 2'b00) : (rresp != 2'b00)));

        if (if_rsp_valid) begin
            if_log.push_back(if_rsp_data); if_err_log.push_back(if_rsp_err); if_rsp_cyc = cyc;
        end
        if (mem_rsp_valid) begin
            mem_log.push_back(mem_rsp_rdata); mem_err_log.push_back(mem_rsp_err); mem_rsp_cyc = cyc;
        end
        if (if_req_ready) if_grant_cyc = cyc;
        if (mem_req_ready) mem_grant_cyc = cyc;
        if (arvalid && arready) begin
            ar_addr_log.push_back(araddr); ar_prot_log.push_back(arprot);
        end
        if (awvalid && awready) aw_hs_cyc = cyc;
        if (wvalid && wready) begin
            w_hs_cyc = cyc; w_seen_data = wdata; w_seen_strb = wstrb;
        end

        // model transition
        if (!rst) begin
            m_busy = 1'b0; m_last_if = 64'd0; m_last_mem = 64'd0;
        end else if (!m_busy) begin
            if (mem_req_valid) begin
                m_busy = 1'b1; m_mem = 1'b1; m_wr = mem_req_wen; m_addr = mem_req_addr[31:0];
                m_wdata = mem_req_wdata; m_wstrb = mem_req_wstrb; m_a = 1'b0; m_w = 1'b0;
            end else if (if_req_valid) begin
                m_busy = 1'b1; m_mem = 1'b0; m_wr = 1'b0; m_addr = if_req_addr[31:0];
                m_a = 1'b0; m_w = 1'b0;
            end
        end else if (!m_wr) begin
            if (!m_a) begin
                if (arready) m_a = 1'b1;
            end else if (rvalid) begin
                m_busy = 1'b0;
                if (m_mem) m_last_mem = rdata; else m_last_if = rdata;
            end
        end else begin
            if (m_a && m_w) begin
                if (bvalid) begin m_busy = 1'b0; m_last_mem = 64'd0; end
            end else begin
                if (!m_a && awready) m_a = 1'b1;
                if (!m_w && wready) m_w = 1'b1;
            end
        end

        // requesters: an accepted request is retired
        if (if_req_valid && if_req_ready) if_pend = 1'b0;
        if (mem_req_valid && mem_req_ready) mem_pend = 1'b0;

        // slave
        if (!rst) begin
            r_pend = 1'b0; b_pend = 1'b0; aw_seen = 1'b0; w_seen = 1'b0;
            ar_cnt = 0; aw_cnt = 0; w_cnt = 0;
        end else begin
            if (r_pend) begin
                if (rvalid && rready) r_pend = 1'b0;
                else if (r_cnt > 0) r_cnt--;
            end
            if (arvalid && arready) begin
                r_pend = 1'b1; r_cnt = lat_pick(rlat) - 1; ar_cnt = 0;
                r_data = (rq_data.size() > 0) ? rq_data.pop_front() : {$urandom, $urandom};
                r_resp = rand_mode ? (($urandom_range(3) == 0) ? 2'($urandom_range(3)) : 2'd0) : d_rresp;
            end else if (arvalid) ar_cnt++;
            if (awvalid && awready) begin aw_seen = 1'b1; aw_cnt = 0; end
            else if (awvalid) aw_cnt++;
            if (wvalid && wready) begin w_seen = 1'b1; w_cnt = 0; end
            else if (wvalid) w_cnt++;
            if (b_pend) begin
                if (bvalid && bready) b_pend = 1'b0;
                else if (b_cnt > 0) b_cnt--;
            end
            if (aw_seen && w_seen) begin
                aw_seen = 1'b0; w_seen = 1'b0; b_pend = 1'b1; b_cnt = lat_pick(blat) - 1;
                b_resp = rand_mode ? (($urandom_range(3) == 0) ? 2'($urandom_range(3)) : 2'd0) : d_bresp;
            end
        end
    end

    initial begin
        rst = 1'b0;
        drive_all();
        repeat (3) tick();
        // reset state
        chk("rst_arvalid", 64'(arvalid), 64'd0);
        chk("rst_awvalid", 64'(awvalid), 64'd0);
        chk("rst_wvalid", 64'(wvalid), 64'd0);
        chk("rst_rready", 64'(rready), 64'd0);
        chk("rst_bready", 64'(bready), 64'd0);
        chk("rst_if_rsp_data", if_rsp_data, 64'd0);
        chk("rst_mem_rsp_rdata", mem_rsp_rdata, 64'd0);
        rst = 1'b1;
        tick();

        // single fetch, data two cycles after AR handshake
        clear_logs();
        ar_wait = 0; rlat = 2;
        rq_data.push_back(64'h0000_0013_0000_0297);
        if_q.push_back(64'h0000_0000_8000_0000);
        wait_if(1, 20);
        chk("t1_araddr", 64'((ar_addr_log.size() > 0) ? ar_addr_log[0] : 32'hx), 64'h8000_0000);
        chk("t1_arprot", 64'((ar_prot_log.size() > 0) ? ar_prot_log[0] : 3'bx), 64'd4);
        chk("t1_data", (if_log.size() > 0) ? if_log[0] : 64'hx, 64'h0000_0013_0000_0297);
        chk("t1_err", 64'((if_err_log.size() > 0) ? if_err_log[0] : 1'bx), 64'd0);
        chk("t1_latency", 64'(if_rsp_cyc - if_grant_cyc), 64'd3);
        repeat (2) tick();

        // simultaneous requests: MEM load first, fetch after return to idle
        clear_logs();
        rlat = 1;
        rq_data.push_back(64'h1111_2222_3333_4444);
        rq_data.push_back(64'h5555_6666_7777_8888);
        mem_q.push_back('{wen: 1'b0, addr: 64'hFFFF_0000_8000_1000, wdata: 64'd0, wstrb: 8'd0});
        if_q.push_back(64'h0000_0000_8000_0040);
        wait_if(1, 30);
        chk("t2_mem_data", (mem_log.size() > 0) ? mem_log[0] : 64'hx, 64'h1111_2222_3333_4444);
        chk("t2_if_data", (if_log.size() > 0) ? if_log[0] : 64'hx, 64'h5555_6666_7777_8888);
        chk("t2_araddr0", 64'((ar_addr_log.size() > 0) ? ar_addr_log[0] : 32'hx), 64'h8000_1000);
        chk("t2_mem_roundtrip", 64'(mem_rsp_cyc - mem_grant_cyc), 64'd2);
        chk("t2_if_grant_after", 64'(if_grant_cyc - mem_rsp_cyc), 64'd1);
        repeat (2) tick();

        // store, W accepted three cycles before AW
        clear_logs();
        w_wait = 0; aw_wait = 3; blat = 1;
        mem_q.push_back('{wen: 1'b1, addr: 64'h0000_0000_8000_2008,
                          wdata: 64'hDEAD_BEEF_0000_0001, wstrb: 8'h0F});
        wait_mem(1, 30);
        repeat (4) tick();
        chk("t3_split", 64'(aw_hs_cyc - w_hs_cyc), 64'd3);
        chk("t3_wdata", w_seen_data, 64'hDEAD_BEEF_0000_0001);
        chk("t3_wstrb", 64'(w_seen_strb), 64'h0F);
        chk("t3_one_rsp", 64'(mem_log.size()), 64'd1);
        chk("t3_rdata0", (mem_log.size() > 0) ? mem_log[0] : 64'hx, 64'd0);
        aw_wait = 0;

        // error propagation on load and store
        clear_logs();
        d_rresp = 2'b10; d_bresp = 2'b11;
        mem_q.push_back('{wen: 1'b0, addr: 64'h8000_3000, wdata: 64'd0, wstrb: 8'd0});
        mem_q.push_back('{wen: 1'b1, addr: 64'h8000_3008, wdata: 64'h42, wstrb: 8'hFF});
        wait_mem(2, 40);
        chk("t4_load_err", 64'((mem_err_log.size() > 0) ? mem_err_log[0] : 1'bx), 64'd1);
        chk("t4_store_err", 64'((mem_err_log.size() > 1) ? mem_err_log[1] : 1'bx), 64'd1);
        d_rresp = 2'b00; d_bresp = 2'b00;
        repeat (2) tick();

        // reset while a fetch waits for its read data
        clear_logs();
        rlat = 5;
        if_q.push_back(64'h8000_0400);
        begin
            int c = 0;
            while (!rready && c < 20) begin tick(); c++; end
        end
        chk("t5_in_r", 64'(rready), 64'd1);
        rst = 1'b0;
        tick();
        chk("t5_arvalid", 64'(arvalid), 64'd0);
        chk("t5_rready", 64'(rready), 64'd0);
        chk("t5_awvalid", 64'(awvalid), 64'd0);
        chk("t5_if_rsp_valid", 64'(if_rsp_valid), 64'd0);
        rst = 1'b1;
        repeat (6) tick();
        chk("t5_no_pulse", 64'(if_log.size()), 64'd0);
        rlat = 1;
        rq_data.push_back(64'hCAFE_F00D_0000_0001);
        if_q.push_back(64'h8000_0408);
        wait_if(1, 20);
        chk("t5_after", (if_log.size() > 0) ? if_log[0] : 64'hx, 64'hCAFE_F00D_0000_0001);

        // four fetches, each AR stalled for five cycles
        clear_logs();
        ar_wait = 5;
        for (int i = 0; i < 4; i++) begin
            rq_data.push_back(64'hA000_0000_0000_0000 + 64'(i));
            if_q.push_back(64'h8000_0100 + 64'(4 * i));
        end
        wait_if(4, 120);
        for (int i = 0; i < 4; i++) begin
            chk("t6_data", (if_log.size() > i) ? if_log[i] : 64'hx, 64'hA000_0000_0000_0000 + 64'(i));
            chk("t6_addr", 64'((ar_addr_log.size() > i) ? ar_addr_log[i] : 32'hx), 64'h8000_0100 + 64'(4 * i));
        end
        ar_wait = 0;

        // randomized traffic with occasional resets
        rand_mode = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk);
            #1;
            rst = ($urandom_range(399) != 0);
            drive_all();
        end
        rst = 1'b1;
        rand_mode = 1'b0;
        repeat (40) tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
